risk_manager_multi: RTL and testbench

Parametrised successor to the single-book pre-trade risk check. Sits between the matching engine and order execution. Tracks a signed position and exposure per participant ID: the buyer is debited long and the seller short on every trade. Uses a 2-stage pipeline, gives a reject reason code for each refused trade, and includes a consecutive-reject kill switch (halt FSM).

---
 rtl/risk_manager_multi.sv | 211 +++++++++++++++++++++
 tb/tb_risk_manager_multi.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/risk_manager_multi.sv
// Two-stage pre-trade risk check with per-participant position/exposure table,
// reject reason codes and a consecutive-reject kill switch. Optional macro: RISK_STATS_EN.
module risk_manager_multi #(
  parameter int NUM_TRADERS    = 16,
  parameter int ID_W           = 8,
  parameter int PRICE_W        = 8,
  parameter int QTY_W          = 8,
  parameter int ACC_W          = 32,
  parameter int MAX_POSITION   = 100,
  parameter int MAX_EXPOSURE   = 5000,
  parameter int HALT_THRESHOLD = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               TRADE_VALID,
  input  logic [PRICE_W-1:0] TRADE_PRICE,
  input  logic [QTY_W-1:0]   TRADE_QTY,
  input  logic [ID_W-1:0]    BUY_ID,
  input  logic [ID_W-1:0]    SELL_ID,
  input  logic               HALT_CLEAR,
  output logic               TRADE_APPROVED,
  output logic               TRADE_REJECTED,
  output logic [2:0]         REJECT_CODE,
  output logic [PRICE_W-1:0] APPR_PRICE,
  output logic [QTY_W-1:0]   APPR_QTY,
  output logic [ID_W-1:0]    APPR_BUY_ID,
  output logic [ID_W-1:0]    APPR_SELL_ID,
  output logic               HALTED,
  output logic [15:0]        APPROVE_COUNT,
  output logic [15:0]        REJECT_COUNT
);

  localparam int PROD_W = PRICE_W + QTY_W;
  localparam int IDX_W  = (NUM_TRADERS > 1) ? $clog2(NUM_TRADERS) : 1;
  localparam int CNT_W  = $clog2(HALT_THRESHOLD + 1);
  localparam logic [ID_W:0]          NUM_IDS = (ID_W+1)'(NUM_TRADERS);
  localparam logic signed [ACC_W:0]  POS_LIM = (ACC_W+1)'(MAX_POSITION);
  localparam logic signed [ACC_W:0]  EXP_LIM = (ACC_W+1)'(MAX_EXPOSURE);
  localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(HALT_THRESHOLD);

  typedef enum logic { ST_NORMAL, ST_HALTED } state_t;
  typedef enum logic [2:0] {
    RC_NONE = 3'd0, RC_BAD_ID = 3'd1, RC_SELF = 3'd2, RC_ZERO = 3'd3,
    RC_POS  = 3'd4, RC_EXP    = 3'd5, RC_HALTED = 3'd6
  } reject_code_t;

  if (PROD_W > ACC_W - 1) begin : g_width_check
    $error("PRICE_W+QTY_W must not exceed ACC_W-1");
  end

  // ---------------- Stage 1: register trade, product and decode flags
  logic               s1_valid_q, s1_bad_id_q, s1_self_q, s1_zero_q;
  logic [PRICE_W-1:0] s1_price_q;
  logic [QTY_W-1:0]   s1_qty_q;
  logic [ID_W-1:0]    s1_buy_q, s1_sell_q;
  logic [ACC_W-1:0]   s1_prod_q;
  logic [PROD_W-1:0]  prod;

  assign prod = PROD_W'(TRADE_QTY) * PROD_W'(TRADE_PRICE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid_q  <= 1'b0;
      s1_bad_id_q <= 1'b0;
      s1_self_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_price_q  <= '0;
      s1_qty_q    <= '0;
      s1_buy_q    <= '0;
      s1_sell_q   <= '0;
      s1_prod_q   <= '0;
    end else begin
      s1_valid_q <= TRADE_VALID;
      if (TRADE_VALID) begin
        s1_bad_id_q <= ({1'b0, BUY_ID} >= NUM_IDS) || ({1'b0, SELL_ID} >= NUM_IDS);
        s1_self_q   <= (BUY_ID == SELL_ID);
        s1_zero_q   <= (TRADE_QTY == '0);
        s1_price_q  <= TRADE_PRICE;
        s1_qty_q    <= TRADE_QTY;
        s1_buy_q    <= BUY_ID;
        s1_sell_q   <= SELL_ID;
        s1_prod_q   <= {{(ACC_W-PROD_W){1'b0}}, prod};
      end
    end
  end

  // ---------------- Stage 2: table read, limit check, write-back
  logic signed [ACC_W-1:0] pos_q [NUM_TRADERS];
  logic signed [ACC_W-1:0] exp_q [NUM_TRADERS];
  logic [IDX_W-1:0]        buy_idx, sell_idx;
  logic signed [ACC_W:0]   qty_ext, prod_ext, buy_pos, buy_exp, sell_pos, sell_exp;
  logic                    pos_bad, exp_bad, approve, reject;
  reject_code_t            code;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  function automatic logic in_lim(input logic signed [ACC_W:0] v,
                                  input logic signed [ACC_W:0] lim);
    return (v <= lim) && (v >= -lim);
  endfunction

  // Out-of-range IDs are steered to entry 0 so the read is always defined; the trade is rejected anyway.
  assign buy_idx  = s1_bad_id_q ? '0 : s1_buy_q[IDX_W-1:0];
  assign sell_idx = s1_bad_id_q ? '0 : s1_sell_q[IDX_W-1:0];
  assign qty_ext  = signed'({{(ACC_W+1-QTY_W){1'b0}}, s1_qty_q});
  assign prod_ext = signed'({1'b0, s1_prod_q});
  assign buy_pos  = signed'({pos_q[buy_idx][ACC_W-1],  pos_q[buy_idx]})  + qty_ext;
  assign buy_exp  = signed'({exp_q[buy_idx][ACC_W-1],  exp_q[buy_idx]})  + prod_ext;
  assign sell_pos = signed'({pos_q[sell_idx][ACC_W-1], pos_q[sell_idx]}) - qty_ext;
  assign sell_exp = signed'({exp_q[sell_idx][ACC_W-1], exp_q[sell_idx]}) - prod_ext;
  assign pos_bad  = !in_lim(buy_pos, POS_LIM) || !in_lim(sell_pos, POS_LIM);
  assign exp_bad  = !in_lim(buy_exp, EXP_LIM) || !in_lim(sell_exp, EXP_LIM);

  // NOTE: every always_comb output gets a default first, otherwise an uncovered path infers a latch.
  always_comb begin
    code = RC_NONE;
    if      (state_q == ST_HALTED) code = RC_HALTED;
    else if (s1_bad_id_q)          code = RC_BAD_ID;
    else if (s1_self_q)            code = RC_SELF;
    else if (s1_zero_q)            code = RC_ZERO;
    else if (pos_bad)              code = RC_POS;
    else if (exp_bad)              code = RC_EXP;
  end

  assign reject  = s1_valid_q && (code != RC_NONE);
  assign approve = s1_valid_q && (code == RC_NONE);

  // NOTE: the table is cleared by reset because a mid-run reset must leave every entry at zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_TRADERS; i++) begin
        pos_q[i] <= '0;
        exp_q[i] <= '0;
      end
    end else if (approve) begin
      pos_q[buy_idx]  <= buy_pos[ACC_W-1:0];
      exp_q[buy_idx]  <= buy_exp[ACC_W-1:0];
      pos_q[sell_idx] <= sell_pos[ACC_W-1:0];
      exp_q[sell_idx] <= sell_exp[ACC_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      TRADE_APPROVED <= 1'b0;
      TRADE_REJECTED <= 1'b0;
      REJECT_CODE    <= '0;
      APPR_PRICE     <= '0;
      APPR_QTY       <= '0;
      APPR_BUY_ID    <= '0;
      APPR_SELL_ID   <= '0;
    end else begin
      TRADE_APPROVED <= approve;
      TRADE_REJECTED <= reject;
      REJECT_CODE    <= reject ? code : RC_NONE;
      if (s1_valid_q) begin
        APPR_PRICE   <= s1_price_q;
        APPR_QTY     <= s1_qty_q;
        APPR_BUY_ID  <= s1_buy_q;
        APPR_SELL_ID <= s1_sell_q;
      end
    end
  end

  // ---------------- Halt FSM
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (HALT_CLEAR) begin
      cnt_d   = '0;
      state_d = ST_NORMAL;
    end else begin
      if (reject && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
      else if (approve)                 cnt_d = '0;
      if (cnt_d == CNT_MAX)             state_d = ST_HALTED;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign HALTED = (state_q == ST_HALTED);

`ifdef RISK_STATS_EN
  logic [15:0] appr_cnt_q, rej_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      appr_cnt_q <= '0;
      rej_cnt_q  <= '0;
    end else begin
      if (TRADE_APPROVED && (appr_cnt_q != 16'hFFFF)) appr_cnt_q <= appr_cnt_q + 16'd1;
      if (TRADE_REJECTED && (rej_cnt_q  != 16'hFFFF)) rej_cnt_q  <= rej_cnt_q  + 16'd1;
    end
  end

  assign APPROVE_COUNT = appr_cnt_q;
  assign REJECT_COUNT  = rej_cnt_q;
`else
  assign APPROVE_COUNT = '0;
  assign REJECT_COUNT  = '0;
`endif

endmodule

// File: tb/tb_risk_manager_multi.sv
// Directed self-checking bench for risk_manager_multi (default parameters).
module tb_risk_manager_multi;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        TRADE_VALID = 1'b0;
  logic [7:0]  TRADE_PRICE = '0, TRADE_QTY = '0, BUY_ID = '0, SELL_ID = '0;
  logic        HALT_CLEAR = 1'b0;
  logic        TRADE_APPROVED, TRADE_REJECTED, HALTED;
  logic [2:0]  REJECT_CODE;
  logic [7:0]  APPR_PRICE, APPR_QTY, APPR_BUY_ID, APPR_SELL_ID;
  logic [15:0] APPROVE_COUNT, REJECT_COUNT;

  int checks   = 0;
  int failures = 0;
  int exp_appr = 0;
  int exp_rej  = 0;

  risk_manager_multi dut (
    .CLK(CLK), .RESET(RESET), .TRADE_VALID(TRADE_VALID), .TRADE_PRICE(TRADE_PRICE),
    .TRADE_QTY(TRADE_QTY), .BUY_ID(BUY_ID), .SELL_ID(SELL_ID), .HALT_CLEAR(HALT_CLEAR),
    .TRADE_APPROVED(TRADE_APPROVED), .TRADE_REJECTED(TRADE_REJECTED),
    .REJECT_CODE(REJECT_CODE), .APPR_PRICE(APPR_PRICE), .APPR_QTY(APPR_QTY),
    .APPR_BUY_ID(APPR_BUY_ID), .APPR_SELL_ID(APPR_SELL_ID), .HALTED(HALTED),
    .APPROVE_COUNT(APPROVE_COUNT), .REJECT_COUNT(REJECT_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Compares the stage-2 result currently on the outputs; code 0 means approval.
  task automatic expect_out(input string tag, input logic [2:0] code);
    check({tag, "_appr"}, 32'(TRADE_APPROVED), 32'(code == 3'd0));
    check({tag, "_rej"},  32'(TRADE_REJECTED), 32'(code != 3'd0));
    check({tag, "_code"}, 32'(REJECT_CODE),    32'(code));
    if (code == 3'd0) exp_appr++;
    else              exp_rej++;
  endtask

  task automatic drive(input logic [7:0] p, input logic [7:0] q,
                       input logic [7:0] b, input logic [7:0] s);
    TRADE_VALID = 1'b1;
    TRADE_PRICE = p;
    TRADE_QTY   = q;
    BUY_ID      = b;
    SELL_ID     = s;
  endtask

  // Single isolated trade; returns on the negedge where its result is visible.
  task automatic trade(input string tag, input logic [7:0] p, input logic [7:0] q,
                       input logic [7:0] b, input logic [7:0] s, input logic [2:0] code);
    @(negedge CLK);
    drive(p, q, b, s);
    @(negedge CLK);
    TRADE_VALID = 1'b0;
    check({tag, "_early"}, 32'(TRADE_APPROVED | TRADE_REJECTED), 32'd0);
    @(negedge CLK);
    expect_out(tag, code);
  endtask

  task automatic check_stats(input string tag, input int appr, input int rej);
`ifdef RISK_STATS_EN
    check({tag, "_appr_cnt"}, 32'(APPROVE_COUNT), 32'(appr));
    check({tag, "_rej_cnt"},  32'(REJECT_COUNT),  32'(rej));
`else
    check({tag, "_appr_cnt"}, 32'(APPROVE_COUNT), 32'd0);
    check({tag, "_rej_cnt"},  32'(REJECT_COUNT),  32'd0);
`endif
  endtask

  initial begin
    int nz;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    check("rst_appr",   32'(TRADE_APPROVED), 32'd0);
    check("rst_rej",    32'(TRADE_REJECTED), 32'd0);
    check("rst_halted", 32'(HALTED),         32'd0);
    check("rst_echo",   32'(APPR_BUY_ID),    32'd0);

    // Basic approval and table update
    trade("t1", 8'd10, 8'd5, 8'd1, 8'd2, 3'd0);
    check("t1_echo_p", 32'(APPR_PRICE), 32'd10);
    check("t1_pos1", dut.pos_q[1], 32'd5);
    check("t1_exp1", dut.exp_q[1], 32'd50);
    check("t1_pos2", dut.pos_q[2], -32'sd5);
    check("t1_exp2", dut.exp_q[2], -32'sd50);
    @(negedge CLK);
    check("t1_pulse_width", 32'(TRADE_APPROVED), 32'd0);
    check_stats("t1", 1, 0);
    exp_appr = 1;

    // Back-to-back stream: 20 approvals reach pos 100, 21st would be 105
    for (int i = 0; i < 23; i++) begin
      if (i >= 2) expect_out("b2b", (i - 2 < 20) ? 3'd0 : 3'd4);
      if (i < 21) drive(8'd1, 8'd5, 8'd3, 8'd4);
      else        TRADE_VALID = 1'b0;
      @(negedge CLK);
    end
    check("b2b_pos3", dut.pos_q[3], 32'd100);
    check("b2b_pos4", dut.pos_q[4], -32'sd100);

    // Exposure limit: 4000 accepted, 8000 refused
    trade("exp1", 8'd100, 8'd40, 8'd5, 8'd6, 3'd0);
    trade("exp2", 8'd100, 8'd40, 8'd5, 8'd6, 3'd5);
    check("exp_exp5", dut.exp_q[5], 32'd4000);

    // Decode rejects, table unchanged, echo and hold
    trade("self", 8'd10, 8'd5, 8'd7, 8'd7, 3'd2);
    trade("badid", 8'd10, 8'd5, 8'd20, 8'd1, 3'd1);
    check("badid_echo", 32'(APPR_BUY_ID), 32'd20);
    @(negedge CLK);
    check("hold_echo", 32'(APPR_BUY_ID), 32'd20);
    check("hold_code", 32'(REJECT_CODE), 32'd0);
    trade("zero", 8'd10, 8'd0, 8'd1, 8'd2, 3'd3);
    check("rej_pos1", dut.pos_q[1], 32'd5);
    check("rej_pos7", dut.pos_q[7], 32'd0);
    check_stats("mid", exp_appr, exp_rej);

    // Kill switch: one approval zeroes the run, then 8 consecutive rejects halt
    trade("prep", 8'd1, 8'd1, 8'd8, 8'd9, 3'd0);
    for (int i = 0; i < 8; i++) begin
      trade("halt_self", 8'd1, 8'd1, 8'd7, 8'd7, 3'd2);
      check("halt_flag", 32'(HALTED), 32'(i == 7));
    end
    trade("halted", 8'd1, 8'd1, 8'd10, 8'd11, 3'd6);
    check("halted_pos10", dut.pos_q[10], 32'd0);
    @(negedge CLK);
    HALT_CLEAR = 1'b1;
    @(negedge CLK);
    HALT_CLEAR = 1'b0;
    check("clear_halted", 32'(HALTED), 32'd0);
    trade("after_clear", 8'd1, 8'd1, 8'd10, 8'd11, 3'd0);
    check("after_pos10", dut.pos_q[10], 32'd1);
    check_stats("pre_rst", exp_appr, exp_rej);

    // Re-engage the halt, then reset with two trades in flight
    for (int i = 0; i < 8; i++) trade("rehalt", 8'd1, 8'd1, 8'd7, 8'd7, 3'd2);
    check("rehalt_flag", 32'(HALTED), 32'd1);
    @(negedge CLK);
    drive(8'd1, 8'd1, 8'd12, 8'd13);
    @(negedge CLK);
    drive(8'd1, 8'd1, 8'd14, 8'd15);
    RESET = 1'b1;
    @(negedge CLK);
    TRADE_VALID = 1'b0;
    RESET = 1'b0;
    nz = 0;
    for (int i = 0; i < 4; i++) begin
      if (TRADE_APPROVED || TRADE_REJECTED) nz++;
      @(negedge CLK);
    end
    check("rst_no_pulse", 32'(nz), 32'd0);
    nz = 0;
    for (int i = 0; i < 16; i++)
      if (dut.pos_q[i] != 0 || dut.exp_q[i] != 0) nz++;
    check("rst_table_zero", 32'(nz), 32'd0);
    check("rst_halted2", 32'(HALTED), 32'd0);
    check_stats("post_rst", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
